// File: rtl/stream_reg_responder.sv
// ============================================================================
// Module   : stream_reg_responder
// Brief    : Byte-stream command responder: 'W' addr data / 'R' addr on the
//            OUT stream, one reply byte on the IN stream, four 8-bit registers.
//            Optional inactivity timeout: define CMD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_reg_responder #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  out_data_i,
    input  logic        out_valid_i,
    output logic        out_ready_o,
    output logic [7:0]  in_data_o,
    output logic        in_valid_o,
    input  logic        in_ready_i,
    output logic [31:0] regs_o,
    output logic        busy_o
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_GET_ADDR = 2'd1;
    localparam logic [1:0] c_ST_GET_DATA = 2'd2;
    localparam logic [1:0] c_ST_REPLY    = 2'd3;

    localparam logic [7:0] c_OP_WRITE = 8'h57;
    localparam logic [7:0] c_OP_READ  = 8'h52;
    localparam logic [7:0] c_RSP_ERR  = 8'h3F;
    localparam logic [7:0] c_RSP_OK   = 8'h4B;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_is_write;
    logic [7:0]       r_addr;
    logic [3:0][7:0]  r_regs;
    logic [7:0]       r_reply;
    logic             r_ready_en;
    logic             w_out_fire;
    logic             w_in_fire;
    logic             w_is_cmd;
    logic             w_timeout;

    assign w_out_fire = out_valid_i & out_ready_o;
    assign w_in_fire  = in_valid_o & in_ready_i;
    assign w_is_cmd   = (out_data_i == c_OP_WRITE) || (out_data_i == c_OP_READ);

`ifdef CMD_TIMEOUT_EN
    logic [23:0] r_tcnt;
    logic        w_waiting;

    assign w_waiting = (r_state == c_ST_GET_ADDR) || (r_state == c_ST_GET_DATA);
    assign w_timeout = w_waiting && (r_tcnt == TIMEOUT_CYCLES - 24'd1);

    // Restarts on every accepted byte so the limit measures host inactivity.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tcnt <= 24'd0;
        end else if (!w_waiting || w_out_fire) begin
            r_tcnt <= 24'd0;
        end else begin
            r_tcnt <= r_tcnt + 24'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_out_fire) begin
                    w_next_state = w_is_cmd ? c_ST_GET_ADDR : c_ST_REPLY;
                end
            end
            c_ST_GET_ADDR: begin
                if (w_out_fire) begin
                    w_next_state = r_is_write ? c_ST_GET_DATA : c_ST_REPLY;
                end else if (w_timeout) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_GET_DATA: begin
                if (w_out_fire) begin
                    w_next_state = c_ST_REPLY;
                end else if (w_timeout) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                if (w_in_fire) begin
                    w_next_state = c_ST_IDLE;
                end
            end
        endcase
    end

    // out_ready_o is held low through reset and rises on the first edge after release.
    always_comb begin
        out_ready_o = r_ready_en && (r_state != c_ST_REPLY);
        in_valid_o  = (r_state == c_ST_REPLY);
        busy_o      = (r_state != c_ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ready_en <= 1'b0;
            r_is_write <= 1'b0;
            r_addr     <= 8'd0;
            r_regs     <= '0;
            r_reply    <= 8'd0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_out_fire) begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_is_write <= (out_data_i == c_OP_WRITE);
                        if (!w_is_cmd) begin
                            r_reply <= c_RSP_ERR;
                        end
                    end
                    c_ST_GET_ADDR: begin
                        r_addr <= out_data_i;
                        if (!r_is_write) begin
                            r_reply <= (out_data_i[7:2] == 6'd0) ? r_regs[out_data_i[1:0]]
                                                                 : c_RSP_ERR;
                        end
                    end
                    c_ST_GET_DATA: begin
                        if (r_addr[7:2] == 6'd0) begin
                            r_regs[r_addr[1:0]] <= out_data_i;
                            r_reply             <= c_RSP_OK;
                        end else begin
                            r_reply <= c_RSP_ERR;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign in_data_o = r_reply;
    assign regs_o    = r_regs;

endmodule

`default_nettype wire

// File: tb/tb_stream_reg_responder.sv
// ============================================================================
// Module   : tb_stream_reg_responder
// Brief    : Scoreboard bench: directed and random commands against a
//            command-level register model; define CMD_TIMEOUT_EN for timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_reg_responder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  out_data_i = 8'd0;
    logic        out_valid_i = 1'b0;
    logic        out_ready_o;
    logic [7:0]  in_data_o;
    logic        in_valid_o;
    logic        in_ready_i = 1'b0;
    logic [31:0] regs_o;
    logic        busy_o;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  model_regs[4];
    int          rdy_mode = 0;
    bit          mon_en = 1'b0;

    stream_reg_responder #(
`ifdef CMD_TIMEOUT_EN
        .TIMEOUT_CYCLES(24'd16)
`else
        .TIMEOUT_CYCLES(24'd12000000)
`endif
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .out_data_i  (out_data_i),
        .out_valid_i (out_valid_i),
        .out_ready_o (out_ready_o),
        .in_data_o   (in_data_o),
        .in_valid_o  (in_valid_o),
        .in_ready_i  (in_ready_i),
        .regs_o      (regs_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word();
        return {model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
    endfunction

    // IN-side backpressure: 0 always ready, 1 random, 2 stalled
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       in_ready_i = 1'b1;
                1:       in_ready_i = 1'($urandom_range(0, 1));
                default: in_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: every presented reply byte must match the queue head; pop on transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rstn && in_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_reply: got 0x%0h with no reply expected at %0t",
                             in_data_o, $time);
                end else begin
                    check("reply_data", {24'd0, in_data_o}, {24'd0, exp_q[0]});
                    if (in_ready_i) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called just after a negedge; returns at the negedge after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        int   t;
        logic rdy;
        t = 0;
        out_data_i  = b;
        out_valid_i = 1'b1;
        do begin
            rdy = out_ready_o;
            @(negedge clk);
            t++;
        end while (!rdy && t < 300);
        if (!rdy) begin
            check("send_timeout", 32'd0, 32'd1);
        end
        out_valid_i = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d);
        logic [7:0] rep;
        int         n;
        if (op == 8'h57) begin
            n = 3;
            if (a < 8'd4) begin
                model_regs[a] = d;
                rep = 8'h4B;
            end else begin
                rep = 8'h3F;
            end
        end else if (op == 8'h52) begin
            n = 2;
            rep = (a < 8'd4) ? model_regs[a] : 8'h3F;
        end else begin
            n = 1;
            rep = 8'h3F;
        end
        exp_q.push_back(rep);
        send_byte(op);
        if (n > 1) send_byte(a);
        if (n > 2) send_byte(d);
        check("reply_latency", {31'd0, in_valid_o}, 32'd1);
        check("regs", regs_o, model_word());
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] op;
        logic [7:0] a;
        for (int i = 0; i < 4; i++) model_regs[i] = 8'd0;

        repeat (3) @(negedge clk);
        check("rst_in_valid", {31'd0, in_valid_o}, 32'd0);
        check("rst_out_ready", {31'd0, out_ready_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_regs", regs_o, 32'd0);
        check("rst_in_data", {24'd0, in_data_o}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_release", {31'd0, out_ready_o}, 32'd1);
        mon_en = 1'b1;

        rdy_mode = 0;
        @(negedge clk);
        cmd(8'h57, 8'h02, 8'hA5);
        check("reg2_written", {24'd0, regs_o[23:16]}, 32'hA5);
        cmd(8'h52, 8'h02, 8'h00);
        cmd(8'h52, 8'h01, 8'h00);
        cmd(8'h57, 8'h08, 8'h11);
        cmd(8'h41, 8'h00, 8'h00);
        drain();

        rdy_mode = 2;
        @(negedge clk);
        @(negedge clk);
        cmd(8'h52, 8'h00, 8'h00);
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", {31'd0, in_valid_o}, 32'd1);
            check("stall_out_ready", {31'd0, out_ready_o}, 32'd0);
            check("stall_data", {24'd0, in_data_o}, {24'd0, model_regs[0]});
            @(negedge clk);
        end
        rdy_mode = 0;
        drain();

`ifdef CMD_TIMEOUT_EN
        send_byte(8'h57);
        repeat (20) @(negedge clk);
        check("timeout_busy", {31'd0, busy_o}, 32'd0);
        check("timeout_no_reply", {31'd0, in_valid_o}, 32'd0);
        cmd(8'h52, 8'h00, 8'h00);
        drain();
`endif

        cmd(8'h57, 8'h03, 8'h5A);
        drain();
        rdy_mode = 2;
        @(negedge clk);
        @(negedge clk);
        cmd(8'h52, 8'h03, 8'h00);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_in_valid", {31'd0, in_valid_o}, 32'd0);
        check("arst_regs", regs_o, 32'd0);
        check("arst_busy", {31'd0, busy_o}, 32'd0);
        check("arst_out_ready", {31'd0, out_ready_o}, 32'd0);
        exp_q.delete();
        for (int i = 0; i < 4; i++) model_regs[i] = 8'd0;
        @(negedge clk);
        rstn = 1'b1;
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_quiet", {31'd0, in_valid_o}, 32'd0);
        end
        cmd(8'h52, 8'h03, 8'h00);
        drain();

        rdy_mode = 1;
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = 8'h57;
                4, 5, 6, 7: op = 8'h52;
                default: begin
                    op = 8'($urandom);
                    if (op == 8'h57 || op == 8'h52) op = 8'h00;
                end
            endcase
            a = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(4, 255));
            cmd(op, a, 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rdy_mode = 0;
        drain();
        check("final_regs", regs_o, model_word());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stream_reg_responder.md
STREAM_REG_RESPONDER -- requirements
Module: stream_reg_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd12000000, inactivity limit in clk cycles for an incomplete command (1 s at 12 MHz).
REQ-002 SHALL have port clk  input  1  app clock, all logic on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port out_data_i  input  8  host-to-device byte from USB CDC OUT stream.
REQ-005 SHALL have port out_valid_i  input  1  out_data_i valid.
REQ-006 SHALL have port out_ready_o  output  1  block accepts out_data_i.
REQ-007 SHALL have port in_data_o  output  8  device-to-host reply byte for USB CDC IN stream.
REQ-008 SHALL have port in_valid_o  output  1  in_data_o valid.
REQ-009 SHALL have port in_ready_i  input  1  IN stream accepts in_data_o.
REQ-010 SHALL have port regs_o  output  32  four 8-bit registers, reg n at bits [8n+7:8n].
REQ-011 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL transfer a byte on a rising edge only when valid and ready are both high (OUT and IN streams).
REQ-013 SHALL implement states IDLE, GET_ADDR, GET_DATA, REPLY; out_ready_o high in IDLE/GET_ADDR/GET_DATA, low in REPLY.
REQ-014 SHALL, in IDLE, on accepted 0x57 ('W') or 0x52 ('R') go to GET_ADDR, recording opcode.
REQ-015 SHALL, in IDLE, on any other accepted byte load reply 0x3F ('?') and go to REPLY.
REQ-016 SHALL, in GET_ADDR, latch address byte; 'R' then goes to REPLY, 'W' goes to GET_DATA.
REQ-017 SHALL treat address with addr[7:2] != 0 as invalid: reply 0x3F, no register written; 'W' with invalid address still consumes its data byte first.
REQ-018 SHALL, for valid 'R', reply with register addr[1:0] contents sampled on the edge the address byte is accepted.
REQ-019 SHALL, for valid 'W', update register addr[1:0] on the edge the data byte is accepted, then reply 0x4B ('K').
REQ-020 SHALL assert in_valid_o on the first edge after the final command byte is accepted (1-cycle latency).
REQ-021 SHALL hold in_valid_o high and in_data_o stable in REPLY until accepted; then return to IDLE with in_valid_o low on that same edge.
REQ-022 SHALL keep in_valid_o low outside REPLY; at most one reply byte per command.
REQ-023 SHALL ignore out_data_i whenever out_ready_o is low (no byte lost: host side stalls).
REQ-024 SHALL allow a new command byte to be accepted the cycle after returning to IDLE (back-to-back commands).

Reset
REQ-025 SHALL, while rstn low, force state IDLE, regs_o=0, in_data_o=0, in_valid_o=0, out_ready_o=0, busy_o=0, timeout counter=0.
REQ-026 SHALL, on reset mid-command or mid-reply, drop in_valid_o immediately and discard the partial command; out_ready_o rises first edge after rstn release.

Configuration
REQ-027 SHALL, with macro CMD_TIMEOUT_EN defined, count cycles in GET_ADDR/GET_DATA since the last accepted byte, clear on each accepted byte, and on reaching TIMEOUT_CYCLES-1 return to IDLE with no reply and no register write.
REQ-028 SHALL, without CMD_TIMEOUT_EN, contain no timeout counter, wait indefinitely in GET_ADDR/GET_DATA, and ignore TIMEOUT_CYCLES.

Verification
REQ-029 SHALL cover: bytes 0x57,0x02,0xA5 with in_ready_i=1 -> regs_o[23:16]=0xA5, single reply 0x4B one cycle after 0xA5 accepted.
REQ-030 SHALL cover: after REQ-029, bytes 0x52,0x02 -> single reply 0xA5; then 0x52,0x01 -> reply 0x00.
REQ-031 SHALL cover: bytes 0x57,0x08,0x11 -> reply 0x3F, regs_o unchanged; byte 0x41 -> reply 0x3F immediately.
REQ-032 SHALL cover: 0x52,0x00 with in_ready_i=0 for 10 cycles -> in_valid_o high, in_data_o stable, out_ready_o low throughout; reply transferred when in_ready_i rises.
REQ-033 SHALL cover: CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16, byte 0x57 then idle 20 cycles -> back in IDLE, busy_o=0, no reply; next 0x52,0x00 answered normally.
REQ-034 SHALL cover: rstn pulsed low while in_valid_o high -> in_valid_o=0 and regs_o=0 asynchronously, no reply after release.
